hdmi_pattern_gen: RTL and testbench

- Pixel source that sits directly downstream of the video timing generator and upstream of the DDR/HDMI output stage.
- Consumes the raw hsync, vsync and data-enable strobes, derives active-area x/y coordinates, and generates one of several test patterns as 24-bit RGB.
- Re-emits syncs and DE delayed so that they stay aligned with the RGB output.
- Pattern selection is frame-synchronous, so no tearing occurs.

---
 rtl/hdmi_pattern_gen.sv | 129 ++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// hdmi_pattern_gen : frame-synchronous 24-bit test-pattern source, 2-cycle latency
// Revision 1.0
// ----------------------------------------------------------------------------
module hdmi_pattern_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int CNT_W      = 12,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_STEP   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [2:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        dataEnable,
  output logic [23:0] RGBchannel,
  output logic        locked,
  output logic [7:0]  frame_count
);

  typedef logic [CNT_W:0] wide_t;

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_ACTIVE - 1);

  logic             hs1, vs1, de1;
  logic             vs_prev;
  logic [CNT_W-1:0] x, y, x1;
  logic             y_chk;
  logic [2:0]       active_pat;
  logic [CNT_W-1:0] bar_pos;
  logic             frame_start, line_end;
  wide_t            bar_next, bar_end;
  logic [2:0]       bar_idx;
  logic [23:0]      pattern_rgb;

  // vs_prev resets low so a reset released inside a vsync pulse cannot fake a frame start
  assign frame_start = vs_prev & ~vsync_in;
  assign line_end    = de1 & ~de_in;
  assign bar_next    = wide_t'(bar_pos) + wide_t'(BAR_STEP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      vs_prev     <= 1'b0;
      de1         <= 1'b0;
      x           <= '0;
      y           <= '0;
      x1          <= '0;
      y_chk       <= 1'b0;
      active_pat  <= 3'd0;
      bar_pos     <= '0;
      locked      <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      hs1     <= hsync_in;
      vs1     <= vsync_in;
      vs_prev <= vsync_in;
      de1     <= de_in;
      x1      <= x;
      y_chk   <= y[CHECK_LOG2];

      if (line_end)
        x <= '0;
      else if (de_in && x != X_MAX)
        x <= x + CNT_W'(1);

      if (frame_start)
        y <= '0;
      else if (line_end && y != Y_MAX)
        y <= y + CNT_W'(1);

      if (frame_start) begin
        locked     <= 1'b1;
        active_pat <= pattern_sel;
        if (locked)
          frame_count <= frame_count + 8'd1;
        if (bar_next >= wide_t'(H_ACTIVE))
          bar_pos <= CNT_W'(bar_next - wide_t'(H_ACTIVE));
        else
          bar_pos <= CNT_W'(bar_next);
      end
    end
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x1 >= CNT_W'((k * H_ACTIVE + 7) / 8))
        bar_idx = 3'(k);
    end
    bar_end     = wide_t'(bar_pos) + wide_t'(16);
    pattern_rgb = 24'h000000;
    case (active_pat)
      3'd0: pattern_rgb = solid_rgb;
      // White..black bar order maps to R=~idx[1], G=~idx[2], B=~idx[0]
      3'd1: pattern_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      3'd2: pattern_rgb = {3{x1[7:0]}};
      3'd3: pattern_rgb = (x1[CHECK_LOG2] ^ y_chk) ? 24'hFFFFFF : 24'h000000;
      3'd4: pattern_rgb = (x1 >= bar_pos && wide_t'(x1) < bar_end) ? 24'hFFFFFF : 24'h000000;
      default: pattern_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      dataEnable <= 1'b0;
      RGBchannel <= 24'h000000;
    end else begin
      hsync      <= hs1;
      vsync      <= vs1;
      dataEnable <= de1 & locked;
      RGBchannel <= (de1 & locked) ? pattern_rgb : 24'h000000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hdmi_pattern_gen : directed, table-driven checks of hdmi_pattern_gen
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_hdmi_pattern_gen;

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b0;
  logic        hsync_in    = 1'b1;
  logic        vsync_in    = 1'b1;
  logic        de_in       = 1'b0;
  logic [2:0]  pattern_sel = 3'd0;
  logic [23:0] solid_rgb   = 24'hA5C33C;
  logic        hsync, vsync, dataEnable, locked;
  logic [23:0] RGBchannel;
  logic [7:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int nfs      = 0;

  logic [23:0] cap_rgb [0:2047];
  logic        cap_de  [0:2047];
  logic        pre_de;

  typedef struct packed {
    logic [11:0] x;
    logic [23:0] rgb;
  } vec_t;
  vec_t bars [12];

  hdmi_pattern_gen #(
    .H_ACTIVE(1920), .V_ACTIVE(1080), .CNT_W(12), .CHECK_LOG2(5), .BAR_STEP(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .dataEnable(dataEnable), .RGBchannel(RGBchannel),
    .locked(locked), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one line of npix pixels; cap_*[i] holds the output two cycles after pixel i
  task automatic run_line(input int npix, input bit fs_at_end);
    for (int j = 0; j <= npix + 1; j++) begin
      de_in    = (j < npix);
      vsync_in = !(fs_at_end && j == npix);
      step();
      if (j == 0) pre_de = dataEnable;
      else begin
        cap_rgb[j-1] = RGBchannel;
        cap_de[j-1]  = dataEnable;
      end
    end
    de_in    = 1'b0;
    vsync_in = 1'b1;
    step();
    if (fs_at_end) nfs++;
  endtask

  task automatic frame();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
    step();
    nfs++;
  endtask

  initial begin
    bars[0]  = '{12'd0,    24'hFFFFFF};
    bars[1]  = '{12'd239,  24'hFFFFFF};
    bars[2]  = '{12'd240,  24'hFFFF00};
    bars[3]  = '{12'd479,  24'hFFFF00};
    bars[4]  = '{12'd480,  24'h00FFFF};
    bars[5]  = '{12'd720,  24'h00FF00};
    bars[6]  = '{12'd960,  24'hFF00FF};
    bars[7]  = '{12'd1200, 24'hFF0000};
    bars[8]  = '{12'd1440, 24'h0000FF};
    bars[9]  = '{12'd1679, 24'h0000FF};
    bars[10] = '{12'd1680, 24'h000000};
    bars[11] = '{12'd1919, 24'h000000};

    // Reset values
    step(); step();
    check("rst hsync",       32'(hsync),       32'd1);
    check("rst vsync",       32'(vsync),       32'd1);
    check("rst dataEnable",  32'(dataEnable),  32'd0);
    check("rst RGBchannel",  32'(RGBchannel),  32'd0);
    check("rst locked",      32'(locked),      32'd0);
    check("rst frame_count", 32'(frame_count), 32'd0);

    // Release mid-frame with colour bars requested: nothing shown before lock
    pattern_sel = 3'd1;
    reset_n     = 1'b1;
    run_line(16, 1'b0);
    for (int i = 0; i <= 16; i++)
      check($sformatf("prelock px%0d", i), 32'({cap_de[i], cap_rgb[i]}), 32'd0);

    // Locking frame start and 2-cycle vsync delay
    check("locked before edge", 32'(locked), 32'd0);
    vsync_in = 1'b0;
    step();
    check("locked after edge", 32'(locked),      32'd1);
    check("fc at lock",        32'(frame_count), 32'd0);
    check("vsync dly0",        32'(vsync),       32'd1);
    vsync_in = 1'b1;
    step();
    check("vsync dly1",        32'(vsync),       32'd0);
    step();
    check("vsync dly2",        32'(vsync),       32'd1);
    nfs = 1;

    // Colour bars on a full line
    run_line(1920, 1'b0);
    for (int i = 0; i < 12; i++)
      check($sformatf("bars x=%0d", bars[i].x), 32'(cap_rgb[bars[i].x]), 32'(bars[i].rgb));
    check("de before px0",  32'(pre_de),       32'd0);
    check("de at px0",      32'(cap_de[0]),    32'd1);
    check("de at px1919",   32'(cap_de[1919]), 32'd1);
    check("de after line",  32'(cap_de[1920]), 32'd0);

    // hsync 2-cycle delay
    hsync_in = 1'b0;
    step();
    check("hsync dly0", 32'(hsync), 32'd1);
    hsync_in = 1'b1;
    step();
    check("hsync dly1", 32'(hsync), 32'd0);
    step();
    check("hsync dly2", 32'(hsync), 32'd1);

    // Checkerboard
    pattern_sel = 3'd3;
    frame();
    run_line(64, 1'b0);
    check("chk x31 y0", 32'(cap_rgb[31]), 32'h000000);
    check("chk x32 y0", 32'(cap_rgb[32]), 32'hFFFFFF);
    for (int l = 1; l < 32; l++) run_line(64, 1'b0);
    run_line(64, 1'b0);
    check("chk x32 y32", 32'(cap_rgb[32]), 32'h000000);
    check("chk x0 y32",  32'(cap_rgb[0]),  32'hFFFFFF);
    // Line 33 ends in the same cycle as a frame start: y must restart at 0
    run_line(64, 1'b1);
    run_line(64, 1'b0);
    check("sim fs x32 y0", 32'(cap_rgb[32]), 32'hFFFFFF);
    check("sim fs x31 y0", 32'(cap_rgb[31]), 32'h000000);

    // Mid-frame pattern change takes effect only at the next frame start
    pattern_sel = 3'd0;
    solid_rgb   = 24'h123456;
    frame();
    run_line(8, 1'b0);
    check("solid line0", 32'(cap_rgb[5]), 32'h123456);
    for (int l = 1; l < 500; l++) run_line(8, 1'b0);
    pattern_sel = 3'd2;
    run_line(8, 1'b0);
    check("solid line500 x5", 32'(cap_rgb[5]), 32'h123456);
    run_line(8, 1'b0);
    check("solid line501 x0", 32'(cap_rgb[0]), 32'h123456);
    frame();
    run_line(8, 1'b0);
    check("ramp x5", 32'(cap_rgb[5]), 32'h050505);
    check("ramp x0", 32'(cap_rgb[0]), 32'h000000);

    // de held for 2000 cycles: x saturates at 1919 (ramp 0x7F)
    run_line(2000, 1'b0);
    check("sat x1918",   32'(cap_rgb[1918]), 32'h7E7E7E);
    check("sat x1919",   32'(cap_rgb[1919]), 32'h7F7F7F);
    check("sat px1920",  32'(cap_rgb[1920]), 32'h7F7F7F);
    check("sat px1999",  32'(cap_rgb[1999]), 32'h7F7F7F);
    run_line(8, 1'b0);
    check("after sat x0", 32'(cap_rgb[0]), 32'h000000);
    check("after sat x5", 32'(cap_rgb[5]), 32'h050505);

    // frame_count wrap and moving bar
    pattern_sel = 3'd4;
    while (nfs < 256) frame();
    check("fc 255", 32'(frame_count), 32'd255);
    frame();
    check("fc wrap", 32'(frame_count), 32'd0);
    run_line(1100, 1'b0);
    check("bar1028 x1027", 32'(cap_rgb[1027]), 32'h000000);
    check("bar1028 x1028", 32'(cap_rgb[1028]), 32'hFFFFFF);
    check("bar1028 x1043", 32'(cap_rgb[1043]), 32'hFFFFFF);
    check("bar1028 x1044", 32'(cap_rgb[1044]), 32'h000000);
    while (nfs < 485) frame();
    check("fc 228", 32'(frame_count), 32'd228);
    run_line(40, 1'b0);
    check("bar20 x19", 32'(cap_rgb[19]), 32'h000000);
    check("bar20 x20", 32'(cap_rgb[20]), 32'hFFFFFF);
    check("bar20 x35", 32'(cap_rgb[35]), 32'hFFFFFF);
    check("bar20 x36", 32'(cap_rgb[36]), 32'h000000);

    // Asynchronous reset in the middle of a line
    de_in = 1'b1;
    step(); step(); step(); step();
    check("midline de on", 32'(dataEnable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async rst de",     32'(dataEnable),  32'd0);
    check("async rst rgb",    32'(RGBchannel),  32'd0);
    check("async rst locked", 32'(locked),      32'd0);
    check("async rst fc",     32'(frame_count), 32'd0);
    step();
    reset_n = 1'b1;
    run_line(16, 1'b0);
    check("post rst de", 32'(cap_de[3]), 32'd0);
    frame();
    run_line(24, 1'b0);
    check("post rst bar x3", 32'(cap_rgb[3]), 32'h000000);
    check("post rst bar x4", 32'(cap_rgb[4]), 32'hFFFFFF);
    check("post rst fc",     32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
